mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Arbitrates the single byte-serial memory engine between IF (fetch, read-only) and
//   MEM (load/store) requesters. Captures the winning request, issues it as a one-cycle
//   start, waits for engine completion and routes rdata plus a done pulse back to the owner.
//   Sits between pipeline stages and the memory engine; the engine only ever sees one client.
// PARAMETERS
//   ADDR_WIDTH    32  address width of requests and engine port
//   STARVE_LIMIT  4   consecutive IF losses before IF is forced to win (guard build only)
//   STARVE_CNT_W  3   starvation counter width; must hold STARVE_LIMIT
// PORTS
//   clk         in   1           clock, rising edge
//   rst         in   1           asynchronous reset, active-high
//   if_req      in   1           IF read request; level, held until if_done
//   if_addr     in   ADDR_WIDTH  IF address
//   if_len      in   3           IF byte count minus 1 (0..3)
//   if_flush    in   1           cancel IF request (branch redirect)
//   if_done     out  1           one-cycle pulse: if_rdata valid
//   if_rdata    out  32          IF read data, zero-extended
//   mem_req     in   1           MEM request; level, held until mem_done
//   mem_we      in   1           1 store, 0 load
//   mem_addr    in   ADDR_WIDTH  MEM address
//   mem_len     in   3           MEM byte count minus 1 (0..3)
//   mem_wdata   in   32          store data, LSB byte first
//   mem_done    out  1           one-cycle pulse: load data valid / store retired
//   mem_rdata   out  32          load data, zero-extended
//   eng_start   out  1           one-cycle engine start strobe
//   eng_we      out  1           engine direction
//   eng_addr    out  ADDR_WIDTH  engine address
//   eng_len     out  3           engine byte count minus 1
//   eng_wdata   out  32          engine write data
//   eng_busy    in   1           engine busy
//   eng_done    in   1           engine completion pulse
//   eng_rdata   in   32          engine read data, valid with eng_done
// BEHAVIOUR
//   - Reset (async): state IDLE, owner none, starvation counter 0, all outputs 0.
//     Any in-flight transaction is abandoned; engine shares rst.
//   - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   - IDLE: grant only when eng_busy=0 and a request is pending.
//     * IF is pending if if_req=1 and if_flush=0.
//     * MEM beats IF, except under the starvation guard.
//     * Grant captures addr/len/we/wdata and the owner. IF grants force eng_we=0.
//     * len values 4..7 saturate to 3.
//   - ISSUE: eng_start=1 for exactly one cycle with the captured fields; -> WAIT.
//     eng_addr/len/we/wdata stay stable from ISSUE until eng_done.
//   - WAIT: hold until eng_done=1; latch eng_rdata (stores: latch 0); -> RESP.
//   - RESP: one-cycle owner done pulse with rdata; -> IDLE.
//     * Minimum latency: req cycle N -> start N+1 -> done no earlier than N+3.
//     * Back-to-back: next grant is the cycle after RESP; requester must drop req on done.
//   - if_flush with IF owning (ISSUE/WAIT/RESP): engine transaction runs to completion,
//     if_done is suppressed, if_rdata unchanged.
//     A flush in the same cycle as an IF grant cancels that grant.
//   - mem_req never cancels; a MEM request arriving mid-IF waits for IDLE.
//   - eng_done outside WAIT is ignored. eng_start is never asserted while eng_busy=1.
//   - Only one of if_done/mem_done may pulse per cycle.
// CONFIGURATION
//   ARB_STARVE_GUARD_EN defined:
//     - Counter increments when IF is pending but MEM wins; clears on an IF grant.
//     - Counter saturates at STARVE_LIMIT; at STARVE_LIMIT IF wins the next arbitration.
//   ARB_STARVE_GUARD_EN undefined:
//     - Strict MEM priority; no counter logic; IF may starve indefinitely.
// TESTING
//   1) if_req, addr 0x100, len 3; engine returns 0xDEADBEEF
//      -> eng_start once, eng_we=0; if_done one cycle, if_rdata=0xDEADBEEF.
//   2) if_req and mem_req (store, 0x2000, wdata 0x55, len 0) in same cycle
//      -> MEM granted first, eng_we=1, eng_len=0; then IF; mem_done precedes if_done.
//   3) IF in WAIT, assert if_flush one cycle
//      -> no if_done; engine completes; pending mem_req granted the cycle after RESP.
//   4) Guard on, STARVE_LIMIT=4, mem_req held continuously with if_req high
//      -> 5th grant goes to IF. Guard off -> IF never granted.
//   5) mem_len=7 -> eng_len=3. eng_done during IDLE -> no done pulse.
//   6) rst asserted in WAIT -> all outputs 0 immediately (async); after release,
//      held if_req is reissued.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-serial memory engine between the IF (fetch) and MEM (load/store) clients.
//
// Ports
//   clk, rst                        clock (rising edge), asynchronous active-high reset
//   if_req/if_addr/if_len/if_flush  fetch request (read-only), byte count minus 1, cancel
//   if_done/if_rdata                fetch completion pulse and zero-extended read data
//   mem_req/mem_we/mem_addr/
//   mem_len/mem_wdata               load/store request
//   mem_done/mem_rdata              load/store completion pulse and zero-extended load data
//   eng_start/eng_we/eng_addr/
//   eng_len/eng_wdata               one-cycle engine start strobe and held command fields
//   eng_busy/eng_done/eng_rdata     engine status, completion pulse and read data
//
// Build option ARB_STARVE_GUARD_EN: adds the IF starvation guard (STARVE_LIMIT consecutive
// IF losses force an IF win); the STARVE_* parameters exist only in that build. Without
// it MEM has strict priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32
`ifdef ARB_STARVE_GUARD_EN
    , parameter int STARVE_LIMIT = 4,
    parameter int STARVE_CNT_W = 3
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic [2:0]            if_len,
    input  logic                  if_flush,
    output logic                  if_done,
    output logic [31:0]           if_rdata,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [2:0]            mem_len,
    input  logic [31:0]           mem_wdata,
    output logic                  mem_done,
    output logic [31:0]           mem_rdata,
    output logic                  eng_start,
    output logic                  eng_we,
    output logic [ADDR_WIDTH-1:0] eng_addr,
    output logic [2:0]            eng_len,
    output logic [31:0]           eng_wdata,
    input  logic                  eng_busy,
    input  logic                  eng_done,
    input  logic [31:0]           eng_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    state_t                state_q, state_d;
    logic                  own_if_q, own_if_d, own_mem_q, own_mem_d;
    logic                  flush_q, flush_d, we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            len_q, len_d, sel_len;
    logic [31:0]           wdata_q, wdata_d, rdata_q, rdata_d;
    logic [31:0]           if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
    logic                  if_pend, grant, pick_if;
`ifdef ARB_STARVE_GUARD_EN
    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);
    logic [STARVE_CNT_W-1:0] starve_q, starve_d;
`endif
    always_comb begin
        if_pend = if_req & ~if_flush;
        grant   = (state_q == S_IDLE) & ~eng_busy & (mem_req | if_pend);
`ifdef ARB_STARVE_GUARD_EN
        pick_if  = if_pend & (~mem_req | (starve_q == LIMIT));
        starve_d = !grant ? starve_q : pick_if ? '0 :
                   (if_pend && starve_q != LIMIT) ? starve_q + 1'b1 : starve_q;
`else
        pick_if = ~mem_req;
`endif
        sel_len   = pick_if ? if_len : mem_len;
        state_d   = state_q;
        own_if_d  = own_if_q;
        own_mem_d = own_mem_q;
        we_d      = we_q;
        addr_d    = addr_q;
        len_d     = len_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        // A flush only matters while IF owns the engine; the transaction itself still completes.
        flush_d   = (state_q == S_IDLE) ? 1'b0 : flush_q | (own_if_q & if_flush);
        case (state_q)
            S_IDLE: if (grant) begin
                state_d   = S_ISSUE;
                own_if_d  = pick_if;
                own_mem_d = ~pick_if;
                we_d      = ~pick_if & mem_we;
                addr_d    = pick_if ? if_addr : mem_addr;
                len_d     = sel_len[2] ? 3'd3 : sel_len;
                wdata_d   = pick_if ? 32'd0 : mem_wdata;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: if (eng_done) begin
                state_d = S_RESP;
                rdata_d = we_q ? 32'd0 : eng_rdata;
            end
            default: begin
                state_d   = S_IDLE;
                own_if_d  = 1'b0;
                own_mem_d = 1'b0;
            end
        endcase
        if_done     = (state_q == S_RESP) & own_if_q & ~flush_q & ~if_flush;
        mem_done    = (state_q == S_RESP) & own_mem_q;
        // Read data is presented with the done pulse and then held until the next delivery.
        if_rdata    = if_done ? rdata_q : if_rdata_q;
        mem_rdata   = mem_done ? rdata_q : mem_rdata_q;
        if_rdata_d  = if_rdata;
        mem_rdata_d = mem_rdata;
        eng_start   = (state_q == S_ISSUE);
        eng_we      = we_q;
        eng_addr    = addr_q;
        eng_len     = len_q;
        eng_wdata   = wdata_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            own_if_q    <= 1'b0;
            own_mem_q   <= 1'b0;
            flush_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
`ifdef ARB_STARVE_GUARD_EN
            starve_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            own_if_q    <= own_if_d;
            own_mem_q   <= own_mem_d;
            flush_q     <= flush_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
`ifdef ARB_STARVE_GUARD_EN
            starve_q    <= starve_d;
`endif
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_done;
    logic [31:0] if_addr, if_rdata;
    logic [2:0]  if_len;
    logic        mem_req, mem_we, mem_done;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_len;
    logic        eng_start, eng_we, eng_busy, eng_done;
    logic [31:0] eng_addr, eng_wdata, eng_rdata;
    logic [2:0]  eng_len;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_if = 0;
    logic [31:0] last_mem = 0;

    mem_arbiter #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_len(if_len), .if_flush(if_flush),
        .if_done(if_done), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .eng_start(eng_start), .eng_we(eng_we), .eng_addr(eng_addr), .eng_len(eng_len),
        .eng_wdata(eng_wdata), .eng_busy(eng_busy), .eng_done(eng_done), .eng_rdata(eng_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] sat(input logic [2:0] l);
        return (l > 3'd3) ? 3'd3 : l;
    endfunction

    // One engine transaction as seen from outside: wait for the start strobe, check the command,
    // let the engine take dly cycles, return rd, then check which client is told and with what.
    task automatic run_txn(input bit own_mem, input logic we, input logic [31:0] addr,
                           input logic [2:0] len, input logic [31:0] wd, input logic [31:0] rd,
                           input int dly, input bit flush);
        logic [31:0] exp;
        for (int n = 0; n < 20 && !eng_start; n++) step();
        chk("start_seen", {31'd0, eng_start}, 1);
        chk("eng_we", {31'd0, eng_we}, {31'd0, we});
        chk("eng_addr", eng_addr, addr);
        chk("eng_len", {29'd0, eng_len}, {29'd0, len});
        if (own_mem && we) chk("eng_wdata", eng_wdata, wd);
        step();
        chk("start_one_cycle", {31'd0, eng_start}, 0);
        eng_busy = 1'b1;
        if (flush) begin
            if_flush = 1'b1;
            mem_req  = 1'b1;
            step();
            if_flush = 1'b0;
        end
        for (int i = 0; i < dly; i++) begin
            step();
            chk("no_early_done", {30'd0, if_done, mem_done}, 0);
            chk("addr_stable", eng_addr, addr);
        end
        eng_done  = 1'b1;
        eng_rdata = rd;
        step();
        eng_done  = 1'b0;
        eng_busy  = 1'b0;
        eng_rdata = $urandom;
        exp = we ? 32'd0 : rd;
        if (own_mem) last_mem = exp;
        else if (!flush) last_if = exp;
        chk("if_done", {31'd0, if_done}, {31'd0, !own_mem && !flush});
        chk("mem_done", {31'd0, mem_done}, {31'd0, own_mem});
        chk("if_rdata", if_rdata, last_if);
        chk("mem_rdata", mem_rdata, last_mem);
        if (own_mem) mem_req = 1'b0;
        else if_req = 1'b0;
    endtask

    task automatic raise_if();
        if_addr = $urandom;
        if_len  = 3'($urandom_range(7, 0));
        if_req  = 1'b1;
    endtask

    task automatic raise_mem();
        mem_we    = 1'($urandom_range(1, 0));
        mem_addr  = $urandom;
        mem_len   = 3'($urandom_range(7, 0));
        mem_wdata = $urandom;
        mem_req   = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        bit          w_if;
        int          losses;
        rst = 1'b1; if_req = 0; if_addr = 0; if_len = 0; if_flush = 0;
        mem_req = 0; mem_we = 0; mem_addr = 0; mem_len = 0; mem_wdata = 0;
        eng_busy = 0; eng_done = 0; eng_rdata = 0;
        step(); step();
        rst = 1'b0;
        chk("rst_outputs", {eng_start, eng_we, eng_len, if_done, mem_done}, 0);
        chk("rst_rdata", if_rdata | mem_rdata | eng_addr | eng_wdata, 0);

        // Plain fetch.
        if_addr = 32'h100; if_len = 3'd3; if_req = 1'b1;
        run_txn(0, 0, 32'h100, 3'd3, 0, 32'hDEADBEEF, 2, 0);
        step();
        chk("if_done_one_cycle", {31'd0, if_done}, 0);
        chk("if_rdata_held", if_rdata, 32'hDEADBEEF);

        // Simultaneous requests: MEM store first, then IF.
        if_addr = 32'h300; if_len = 3'd1; if_req = 1'b1;
        mem_we = 1'b1; mem_addr = 32'h2000; mem_wdata = 32'h55; mem_len = 3'd0; mem_req = 1'b1;
        run_txn(1, 1, 32'h2000, 3'd0, 32'h55, 32'h12345678, 1, 0);
        run_txn(0, 0, 32'h300, 3'd1, 0, 32'hA5A5_0001, 0, 0);
        step();

        // Engine busy blocks the grant.
        eng_busy = 1'b1; if_addr = 32'h340; if_len = 3'd2; if_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("busy_no_start", {31'd0, eng_start}, 0);
        end
        eng_busy = 1'b0;
        run_txn(0, 0, 32'h340, 3'd2, 0, 32'h0BAD_F00D, 1, 0);
        step();

        // Flush while IF waits; a MEM load raised at the same time follows right after RESP.
        if_addr = 32'h400; if_len = 3'd3; if_req = 1'b1;
        mem_we = 1'b0; mem_addr = 32'h4400; mem_len = 3'd2; mem_wdata = 0;
        run_txn(0, 0, 32'h400, 3'd3, 0, 32'hCAFE_BABE, 2, 1);
        chk("flush_if_rdata_kept", if_rdata, 32'h0BAD_F00D);
        step();
        chk("b2b_idle_no_start", {31'd0, eng_start}, 0);
        step();
        chk("b2b_start", {31'd0, eng_start}, 1);
        run_txn(1, 0, 32'h4400, 3'd2, 0, 32'h0000_7788, 1, 0);
        step();

        // Flush in the grant cycle cancels the IF grant.
        if_addr = 32'h480; if_len = 3'd0; if_req = 1'b1; if_flush = 1'b1;
        step(); step();
        chk("flush_cancels_grant", {31'd0, eng_start}, 0);
        if_flush = 1'b0;
        run_txn(0, 0, 32'h480, 3'd0, 0, 32'h0000_00EE, 0, 0);
        step();

        // MEM held continuously with IF pending.
        if_addr = 32'h700; if_len = 3'd2; if_req = 1'b1;
        mem_we = 1'b0; mem_addr = 32'h800; mem_len = 3'd1; mem_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
`ifdef ARB_STARVE_GUARD_EN
            w_if = (i == 4);
`else
            w_if = 1'b0;
`endif
            if (w_if) run_txn(0, 0, 32'h700, 3'd2, 0, 32'h1000 + i, 1, 0);
            else run_txn(1, 0, 32'h800, 3'd1, 0, 32'h2000 + i, 1, 0);
            if_req  = 1'b1;
            mem_req = 1'b1;
        end
        if_req = 1'b0; mem_req = 1'b0;
        step();

        // Length saturation, and a stray engine completion while idle.
        mem_we = 1'b0; mem_addr = 32'h900; mem_len = 3'd7; mem_req = 1'b1;
        run_txn(1, 0, 32'h900, 3'd3, 0, 32'h00C0_FFEE, 0, 0);
        step();
        eng_done = 1'b1; eng_rdata = 32'hFFFF_FFFF;
        step();
        eng_done = 1'b0;
        step();
        chk("idle_eng_done_ignored", {30'd0, if_done, mem_done}, 0);
        chk("idle_no_start", {31'd0, eng_start}, 0);

        // Asynchronous reset in WAIT, then the held fetch is reissued.
        if_addr = 32'h600; if_len = 3'd1; if_req = 1'b1;
        for (int n = 0; n < 20 && !eng_start; n++) step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ctrl", {eng_start, eng_we, eng_len, if_done, mem_done}, 0);
        chk("async_rst_data", if_rdata | mem_rdata | eng_addr | eng_wdata, 0);
        step();
        rst = 1'b0;
        last_if = 0; last_mem = 0;
        run_txn(0, 0, 32'h600, 3'd1, 0, 32'h6060_6060, 1, 0);

        // Randomized traffic against the arbitration rules.
        losses = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            for (int t = 0; t < 30 && !if_req && !mem_req; t++) begin
                if ($urandom_range(1, 0) == 1) raise_if();
                if ($urandom_range(1, 0) == 1) raise_mem();
                if (!if_req && !mem_req) step();
            end
            if (!if_req && !mem_req) raise_mem();
`ifdef ARB_STARVE_GUARD_EN
            w_if = if_req && (!mem_req || losses == 4);
`else
            w_if = !mem_req;
`endif
            if (w_if) losses = 0;
            else if (if_req && losses < 4) losses++;
            rd = $urandom;
            if (w_if) run_txn(0, 0, if_addr, sat(if_len), 0, rd, $urandom_range(3, 0), 0);
            else run_txn(1, mem_we, mem_addr, sat(mem_len), mem_wdata, rd, $urandom_range(3, 0), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
